// File: rtl/key_press_decoder.sv
// Turns a debounced key level into short-press, long-press and double-click pulses,
// with one toggling LED bit per event type and a wrapping event counter.
module key_press_decoder #(
  parameter int unsigned LONG_TIME  = 50_000_000,
  parameter int unsigned DCLICK_GAP = 15_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic [2:0] led,
  output logic [7:0] evt_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HELD,
    WAIT_GAP,
    PRESS2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_d;
  logic             rise, fall;
  logic             short_nxt, long_nxt, dbl_nxt;

  assign rise = key_in & ~key_d;
  assign fall = ~key_in & key_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        // A release on the terminal-count edge still counts as a short press.
        if (fall) begin
          state_nxt = WAIT_GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_HELD;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (fall) state_nxt = IDLE;
      end
      WAIT_GAP: begin
        if (rise) begin
          state_nxt = PRESS2;
        end else if (cnt == DCLICK_LAST) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESS2: begin
        if (fall) begin
          dbl_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      key_d        <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      led          <= '0;
      evt_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      key_d        <= key_in;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= dbl_nxt;
      led          <= led ^ {dbl_nxt, long_nxt, short_nxt};
      if (short_nxt | long_nxt | dbl_nxt) evt_cnt <= evt_cnt + 8'd1;
    end
  end

endmodule
